// File: rtl/imsic_intp_files.sv
// Bank of IMSIC interrupt files (M, S, VS...): MSI-set pending bits, per-file
// enable/threshold/delivery, registered lowest-eligible top identity and irq.
module imsic_intp_files #(
  parameter  int NrIntpFiles = 3,
  parameter  int NrSources   = 32,
  localparam int IdW         = $clog2(NrSources),
  localparam int FileW       = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // MSI handshake: a write is accepted on any rising edge where msi_valid_i
  // and msi_ready_o are both high; ready is high whenever out of reset.
  input  logic                         msi_valid_i,
  output logic                         msi_ready_o,
  input  logic [FileW-1:0]             msi_file_i,
  input  logic [IdW-1:0]               msi_id_i,
  input  logic                         en_we_i,
  input  logic [FileW-1:0]             en_file_i,
  input  logic [IdW-1:0]               en_id_i,
  input  logic                         en_val_i,
  input  logic                         thr_we_i,
  input  logic [FileW-1:0]             thr_file_i,
  input  logic [IdW-1:0]               thr_i,
  input  logic                         dlv_we_i,
  input  logic [FileW-1:0]             dlv_file_i,
  input  logic                         dlv_i,
  input  logic                         claim_i,
  input  logic [FileW-1:0]             claim_file_i,
  output logic [NrIntpFiles*IdW-1:0]   topei_o,
  output logic [NrIntpFiles-1:0]       irq_o
);

  logic [NrIntpFiles-1:0][NrSources-1:0] pending_q, pending_d;
  logic [NrIntpFiles-1:0][NrSources-1:0] enable_q, enable_d;
  logic [NrIntpFiles-1:0][IdW-1:0]       thr_q, thr_d;
  logic [NrIntpFiles-1:0]                dlv_q, dlv_d;
  logic [NrIntpFiles-1:0][IdW-1:0]       top_q, top_d;
  logic [NrIntpFiles-1:0]                irq_q, irq_d;

  assign msi_ready_o = rst_ni;

  always_comb begin
    pending_d = pending_q;
    enable_d  = enable_q;
    thr_d     = thr_q;
    dlv_d     = dlv_q;
    for (int f = 0; f < NrIntpFiles; f++) begin
      // Claim first, MSI second, so a same-cycle MSI to the claimed id survives.
      if (claim_i && int'(claim_file_i) == f && top_q[f] != '0)
        pending_d[f][top_q[f]] = 1'b0;
      if (msi_valid_i && int'(msi_file_i) == f && msi_id_i != '0)
        pending_d[f][msi_id_i] = 1'b1;
      if (en_we_i && int'(en_file_i) == f && en_id_i != '0)
        enable_d[f][en_id_i] = en_val_i;
      if (thr_we_i && int'(thr_file_i) == f)
        thr_d[f] = thr_i;
      if (dlv_we_i && int'(dlv_file_i) == f)
        dlv_d[f] = dlv_i;
      pending_d[f][0] = 1'b0;
      enable_d[f][0]  = 1'b0;
    end
  end

  // Top identity is taken from the current state so it trails a change by one edge.
  always_comb begin
    top_d = '0;
    irq_d = '0;
    for (int f = 0; f < NrIntpFiles; f++) begin
      for (int i = NrSources - 1; i >= 1; i--) begin
        if (pending_q[f][i] && enable_q[f][i] &&
            (thr_q[f] == '0 || i < int'(thr_q[f])))
          top_d[f] = IdW'(i);
      end
      irq_d[f] = dlv_q[f] & (top_d[f] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      enable_q  <= '0;
      thr_q     <= '0;
      dlv_q     <= '0;
      top_q     <= '0;
      irq_q     <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      thr_q     <= thr_d;
      dlv_q     <= dlv_d;
      top_q     <= top_d;
      irq_q     <= irq_d;
    end
  end

  assign topei_o = top_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_imsic_intp_files.sv
// Directed bench for imsic_intp_files: expected values queued as stimulus is
// driven, popped and asserted when outputs are sampled #1 after the edge.
module tb_imsic_intp_files;
  localparam int NF = 3;
  localparam int NS = 32;
  localparam int IW = 5;
  localparam int FW = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             msi_valid_i = 1'b0;
  logic             msi_ready_o;
  logic [FW-1:0]    msi_file_i = '0;
  logic [IW-1:0]    msi_id_i = '0;
  logic             en_we_i = 1'b0;
  logic [FW-1:0]    en_file_i = '0;
  logic [IW-1:0]    en_id_i = '0;
  logic             en_val_i = 1'b0;
  logic             thr_we_i = 1'b0;
  logic [FW-1:0]    thr_file_i = '0;
  logic [IW-1:0]    thr_i = '0;
  logic             dlv_we_i = 1'b0;
  logic [FW-1:0]    dlv_file_i = '0;
  logic             dlv_i = 1'b0;
  logic             claim_i = 1'b0;
  logic [FW-1:0]    claim_file_i = '0;
  logic [NF*IW-1:0] topei_o;
  logic [NF-1:0]    irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  imsic_intp_files #(.NrIntpFiles(NF), .NrSources(NS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .msi_valid_i(msi_valid_i), .msi_ready_o(msi_ready_o),
    .msi_file_i(msi_file_i), .msi_id_i(msi_id_i),
    .en_we_i(en_we_i), .en_file_i(en_file_i), .en_id_i(en_id_i), .en_val_i(en_val_i),
    .thr_we_i(thr_we_i), .thr_file_i(thr_file_i), .thr_i(thr_i),
    .dlv_we_i(dlv_we_i), .dlv_file_i(dlv_file_i), .dlv_i(dlv_i),
    .claim_i(claim_i), .claim_file_i(claim_file_i),
    .topei_o(topei_o), .irq_o(irq_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] top(input int f);
    return topei_o[f*IW +: IW];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    tick();
    msi_valid_i = 1'b0;
    en_we_i     = 1'b0;
    thr_we_i    = 1'b0;
    dlv_we_i    = 1'b0;
    claim_i     = 1'b0;
  endtask

  task automatic drv_msi(input int f, input int id);
    msi_valid_i = 1'b1;
    msi_file_i  = FW'(f);
    msi_id_i    = IW'(id);
  endtask

  task automatic drv_en(input int f, input int id, input logic v);
    en_we_i   = 1'b1;
    en_file_i = FW'(f);
    en_id_i   = IW'(id);
    en_val_i  = v;
  endtask

  task automatic drv_thr(input int f, input int t);
    thr_we_i   = 1'b1;
    thr_file_i = FW'(f);
    thr_i      = IW'(t);
  endtask

  task automatic drv_dlv(input int f, input logic v);
    dlv_we_i   = 1'b1;
    dlv_file_i = FW'(f);
    dlv_i      = v;
  endtask

  task automatic drv_claim(input int f);
    claim_i      = 1'b1;
    claim_file_i = FW'(f);
  endtask

  // scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0d with no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    // reset state
    #1;
    expect_val(0); check("rst_topei", 32'(topei_o));
    expect_val(0); check("rst_irq", 32'(irq_o));
    expect_val(0); check("rst_ready", 32'(msi_ready_o));
    tick(); tick();
    rst_ni = 1'b1;
    #1;
    expect_val(1); check("ready_after_rst", 32'(msi_ready_o));

    // file1 id5 delivered
    drv_en(1, 5, 1'b1); drv_dlv(1, 1'b1); step();
    drv_msi(1, 5); step();
    step();
    expect_val(5); check("f1_topei", 32'(top(1)));
    expect_val(0); check("f1_other0", 32'(top(0)));
    expect_val(0); check("f1_other2", 32'(top(2)));
    expect_val(32'b010); check("f1_irq", 32'(irq_o));
    drv_claim(1); step();
    step();
    expect_val(0); check("f1_claimed", 32'(top(1)));
    expect_val(0); check("f1_irq_clr", 32'(irq_o));

    // file0 threshold masking
    drv_en(0, 3, 1'b1); step();
    drv_en(0, 9, 1'b1); drv_thr(0, 9); step();
    drv_msi(0, 3); step();
    drv_msi(0, 9); step();
    step();
    expect_val(3); check("thr_low", 32'(top(0)));
    drv_claim(0); step();
    step();
    expect_val(0); check("thr_masked", 32'(top(0)));
    drv_thr(0, 0); step();
    step();
    expect_val(9); check("thr_off", 32'(top(0)));
    drv_claim(0); step();
    step();
    expect_val(0); check("thr_cleanup", 32'(top(0)));

    // file2 claim racing an MSI to the same id
    drv_en(2, 7, 1'b1); step();
    drv_msi(2, 7); step();
    step();
    expect_val(7); check("race_pre", 32'(top(2)));
    drv_claim(2); drv_msi(2, 7); step();
    step();
    expect_val(7); check("race_msi_wins", 32'(top(2)));
    drv_claim(2); step();
    step();
    expect_val(0); check("race_cleanup", 32'(top(2)));

    // out-of-range file and id 0 are dropped
    drv_en(0, 0, 1'b1); step();
    drv_en(3, 5, 1'b1); step();
    drv_msi(3, 5); step();
    drv_msi(0, 0); step();
    step();
    expect_val(0); check("drop_topei", 32'(topei_o));
    expect_val(0); check("drop_irq", 32'(irq_o));

    // delivery gating and enable re-exposure
    drv_en(0, 4, 1'b1); step();
    drv_msi(0, 4); step();
    step();
    expect_val(4); check("dlv0_topei", 32'(top(0)));
    expect_val(0); check("dlv0_irq", 32'(irq_o));
    drv_dlv(0, 1'b1); step();
    step();
    expect_val(32'b001); check("dlv1_irq", 32'(irq_o));
    drv_en(0, 4, 1'b0); step();
    step();
    expect_val(0); check("en_off_topei", 32'(top(0)));
    expect_val(0); check("en_off_irq", 32'(irq_o));
    drv_en(0, 4, 1'b1); step();
    step();
    expect_val(4); check("en_on_topei", 32'(top(0)));
    drv_claim(0); step();
    step();
    expect_val(0); check("dlv_cleanup", 32'(top(0)));

    // reset mid-operation
    drv_en(0, 6, 1'b1); step();
    drv_msi(0, 6); step();
    step();
    expect_val(6); check("pre_rst_topei", 32'(top(0)));
    expect_val(32'b001); check("pre_rst_irq", 32'(irq_o));
    #2;
    rst_ni = 1'b0;
    #1;
    expect_val(0); check("async_rst_topei", 32'(topei_o));
    expect_val(0); check("async_rst_irq", 32'(irq_o));
    expect_val(0); check("async_rst_ready", 32'(msi_ready_o));
    drv_msi(0, 6); step();
    rst_ni = 1'b1;
    drv_en(0, 6, 1'b1); step();
    step();
    step();
    expect_val(0); check("post_rst_no_pending", 32'(topei_o));
    drv_msi(0, 6); step();
    step();
    expect_val(6); check("post_rst_new_msi", 32'(top(0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
